rubik_rd_req_issuer: RTL and testbench

Read-request initiator for the RUBIK read path. Accepts one transfer command at a time and splits it into 64-byte read requests toward the DMA. Each issued request reserves one latency-FIFO credit; a credit is returned by the response-side pop (`rd_cdt_lat_fifo_pop`). Requests never outnumber the response buffer space.

---
 rtl/rubik_rd_pkg.sv | 38 +++
 rtl/rubik_rd_req_issuer_if.sv | 44 ++++
 rtl/rubik_cdt_cnt.sv | 50 +++++
 rtl/rubik_rd_req_issuer.sv | 105 ++++++++++
 tb/tb_rubik_rd_req_issuer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rubik_rd_pkg.sv
// Shared types and constants for the RUBIK read-request path.
// Payload layout, FSM encoding and line-size helpers.
package rubik_rd_pkg;

  localparam int LAT_FIFO_DEPTH_DEF = 128;
  localparam int LINE_BYTES = 64;
  localparam int HALF_LINES = 2;

  typedef struct packed {
    logic [1:0]  mask;
    logic [63:0] addr;
  } rd_req_pd_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } iss_state_e;

  function automatic logic [63:0] line_align64(
    input logic [63:0] a
  );
    return a & ~64'(LINE_BYTES - 1);
  endfunction

  function automatic logic [31:0] line_align32(
    input logic [31:0] a
  );
    return a & ~32'(LINE_BYTES - 1);
  endfunction

  // An empty half-line mask means the whole line.
  function automatic logic [1:0] norm_mask(
    input logic [1:0] m
  );
    return (m == 2'b00) ? 2'b11 : m;
  endfunction

endpackage

// File: rtl/rubik_rd_req_issuer_if.sv
// Command and read-request handshakes of the RUBIK read initiator.
// slave = the issuer, master = command source / DMA side.
interface rubik_rd_req_issuer_if
  import rubik_rd_pkg::*;
#(
  parameter int LINES_W = 13
) ();

  logic               cmd_vld;
  logic               cmd_rdy;
  logic [63:0]        cmd_addr;
  logic [LINES_W-1:0] cmd_lines;
  logic [31:0]        cmd_stride;
  logic [1:0]         cmd_last_mask;

  logic               rd_req_vld;
  logic               rd_req_rdy;
  rd_req_pd_t         rd_req_pd;

  modport slave (
    input  cmd_vld,
    output cmd_rdy,
    input  cmd_addr,
    input  cmd_lines,
    input  cmd_stride,
    input  cmd_last_mask,
    output rd_req_vld,
    input  rd_req_rdy,
    output rd_req_pd
  );

  modport master (
    output cmd_vld,
    input  cmd_rdy,
    output cmd_addr,
    output cmd_lines,
    output cmd_stride,
    output cmd_last_mask,
    input  rd_req_vld,
    output rd_req_rdy,
    input  rd_req_pd
  );

endinterface

// File: rtl/rubik_cdt_cnt.sv
// Credit counter: take consumes, give returns, saturates at DEPTH.
// A give at full leaves the count alone and sets a sticky error.
module rubik_cdt_cnt #(
  parameter int DEPTH = 128,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          take,
  input  logic          give,
  output logic [CW-1:0] credits,
  output logic          avail,
  output logic          err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          err_q;
  logic          err_nxt;

  always_comb begin
    cnt_nxt = cnt_q;
    err_nxt = err_q;
    unique case ({take, give})
      2'b10: cnt_nxt = cnt_q - CW'(1);
      2'b01: begin
        if (cnt_q == FULL) err_nxt = 1'b1;
        else cnt_nxt = cnt_q + CW'(1);
      end
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= FULL;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  assign credits = cnt_q;
  assign avail   = (cnt_q != '0);
  assign err     = err_q;

endmodule

// File: rtl/rubik_rd_req_issuer.sv
// RUBIK read-request initiator: splits a command into 64B line
// requests, gated by latency-FIFO credits.
module rubik_rd_req_issuer
  import rubik_rd_pkg::*;
#(
  parameter int LAT_FIFO_DEPTH = LAT_FIFO_DEPTH_DEF,
  parameter int LINES_W = 13
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  rubik_rd_req_issuer_if.slave  io,
  input  logic                  rd_cdt_lat_fifo_pop,
  output logic                  busy,
  output logic                  cdt_err
);

  localparam int CW = $clog2(LAT_FIFO_DEPTH + 1);

  iss_state_e         state;
  iss_state_e         state_nxt;

  logic [63:0]        addr_q;
  logic [LINES_W-1:0] rem_q;
  logic [31:0]        stride_q;
  logic [1:0]         last_mask_q;

  logic               req_vld_q;
  rd_req_pd_t         req_pd_q;

  logic [CW-1:0]      credits;
  logic               cdt_avail;
  logic               accept;
  logic               launch;
  logic               last_line;

  assign last_line = (rem_q == '0);
  assign accept    = (state == IDLE) & io.cmd_vld;
  assign launch    = (state == ISSUE)
                   & (~req_vld_q | io.rd_req_rdy)
                   & cdt_avail;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (io.cmd_vld) state_nxt = ISSUE;
      ISSUE:   if (launch && last_line) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) state <= IDLE;
    else state <= state_nxt;
  end

  // Address generator: latched on accept, advanced per launch.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      addr_q      <= '0;
      rem_q       <= '0;
      stride_q    <= '0;
      last_mask_q <= '0;
    end else if (accept) begin
      addr_q      <= line_align64(io.cmd_addr);
      rem_q       <= io.cmd_lines;
      stride_q    <= line_align32(io.cmd_stride);
      last_mask_q <= norm_mask(io.cmd_last_mask);
    end else if (launch) begin
      addr_q <= addr_q + {32'b0, stride_q};
      if (!last_line) rem_q <= rem_q - LINES_W'(1);
    end
  end

  // Output slot holds its payload until the DMA takes it.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      req_vld_q <= 1'b0;
      req_pd_q  <= '0;
    end else if (launch) begin
      req_vld_q     <= 1'b1;
      req_pd_q.addr <= addr_q;
      req_pd_q.mask <= last_line ? last_mask_q : 2'b11;
    end else if (io.rd_req_rdy) begin
      req_vld_q <= 1'b0;
    end
  end

  rubik_cdt_cnt #(
    .DEPTH (LAT_FIFO_DEPTH)
  ) u_cdt (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .take    (launch),
    .give    (rd_cdt_lat_fifo_pop),
    .credits (credits),
    .avail   (cdt_avail),
    .err     (cdt_err)
  );

  assign io.cmd_rdy    = (state == IDLE);
  assign io.rd_req_vld = req_vld_q;
  assign io.rd_req_pd  = req_pd_q;
  assign busy          = (state == ISSUE) | req_vld_q;

endmodule

// File: tb/tb_rubik_rd_req_issuer.sv
// Scoreboard bench for rubik_rd_req_issuer, built with 4 credits
// so starvation and saturation are reachable quickly.
module tb_rubik_rd_req_issuer;
  import rubik_rd_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW = 13;

  logic clk;
  logic rst;
  logic pop;
  logic busy;
  logic cdt_err;

  rubik_rd_req_issuer_if #(.LINES_W(LW)) io ();

  rubik_rd_req_issuer #(
    .LAT_FIFO_DEPTH (DEPTH),
    .LINES_W        (LW)
  ) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rst      (rst),
    .io                  (io),
    .rd_cdt_lat_fifo_pop (pop),
    .busy                (busy),
    .cdt_err             (cdt_err)
  );

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  logic [65:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [65:0] got,
                     input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor: head of queue must be on the bus whenever valid.
  always @(negedge clk) begin
    if (!rst && io.rd_req_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req got=%h exp=none",
                 io.rd_req_pd);
      end else begin
        chk("req_pd", io.rd_req_pd, exp_q[0]);
        if (io.rd_req_rdy) begin
          void'(exp_q.pop_front());
          acc_cnt++;
        end
      end
    end
  end

  function automatic int cr();
    return int'(dut.u_cdt.credits);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_n(input int n);
    pop = 1'b1;
    repeat (n) tick();
    pop = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic push(input logic [1:0] m,
                      input logic [63:0] a);
    exp_q.push_back({m, a});
  endtask

  task automatic send_cmd(input logic [63:0] a,
                          input logic [LW-1:0] l,
                          input logic [31:0] s,
                          input logic [1:0] m);
    int n = 0;
    while (!io.cmd_rdy && n < 200) begin
      tick();
      n++;
    end
    chk("cmd_rdy_wait", io.cmd_rdy, 1);
    io.cmd_vld       = 1'b1;
    io.cmd_addr      = a;
    io.cmd_lines     = l;
    io.cmd_stride    = s;
    io.cmd_last_mask = m;
    tick();
    io.cmd_vld = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    pop = 1'b0;
    io.cmd_vld       = 1'b0;
    io.cmd_addr      = '0;
    io.cmd_lines     = '0;
    io.cmd_stride    = '0;
    io.cmd_last_mask = '0;
    io.rd_req_rdy    = 1'b1;
    tick();
    tick();
    chk("rst_cmd_rdy", io.cmd_rdy, 1);
    chk("rst_vld", io.rd_req_vld, 0);
    chk("rst_pd", io.rd_req_pd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", cdt_err, 0);
    chk("rst_credits", cr(), DEPTH);
    rst = 1'b0;
    tick();

    // single line, unaligned address
    push(2'b01, 64'h1000_0040);
    send_cmd(64'h1000_0047, 0, 32'h0, 2'b01);
    chk("s1_cmd_rdy", io.cmd_rdy, 0);
    chk("s1_busy", busy, 1);
    chk("s1_vld_early", io.rd_req_vld, 0);
    tick();
    chk("s1_vld", io.rd_req_vld, 1);
    chk("s1_cmd_rdy_back", io.cmd_rdy, 1);
    chk("s1_credits", cr(), DEPTH - 1);
    tick();
    chk("s1_idle", busy, 0);
    pop_n(1);
    chk("s1_credits_ret", cr(), DEPTH);

    // full-rate burst
    push(2'b11, 64'h2000);
    push(2'b11, 64'h2100);
    push(2'b11, 64'h2200);
    push(2'b11, 64'h2300);
    send_cmd(64'h2000, 3, 32'h100, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("burst_vld", io.rd_req_vld, 1);
      tick();
    end
    chk("burst_end_vld", io.rd_req_vld, 0);
    chk("burst_end_busy", busy, 0);
    chk("burst_credits", cr(), 0);
    pop_n(4);
    chk("burst_credits_ret", cr(), DEPTH);

    // starvation
    base = acc_cnt;
    for (int i = 0; i < 8; i++)
      push(2'b11, 64'h3000 + 64'(i) * 64'h40);
    send_cmd(64'h3000, 7, 32'h40, 2'b11);
    tick();
    repeat (4) begin
      chk("starve_vld", io.rd_req_vld, 1);
      tick();
    end
    chk("starve_stop_vld", io.rd_req_vld, 0);
    chk("starve_busy", busy, 1);
    chk("starve_credits", cr(), 0);
    chk("starve_count4", acc_cnt - base, 4);
    repeat (3) tick();
    chk("starve_hold", io.rd_req_vld, 0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pop_lat_m1", io.rd_req_vld, 0);
    tick();
    chk("pop_lat_m2", io.rd_req_vld, 1);
    tick();
    chk("pop_one_only", io.rd_req_vld, 0);
    chk("starve_count5", acc_cnt - base, 5);
    pop_n(3);
    wait_idle("starve_done");
    chk("starve_count8", acc_cnt - base, 8);
    chk("starve_credits_end", cr(), 0);
    pop_n(4);

    // backpressure mid-burst
    push(2'b11, 64'h4000);
    push(2'b11, 64'h4080);
    push(2'b11, 64'h4100);
    push(2'b10, 64'h4180);
    send_cmd(64'h4000, 3, 32'h80, 2'b10);
    tick();
    io.rd_req_rdy = 1'b0;
    repeat (5) begin
      chk("bp_vld", io.rd_req_vld, 1);
      chk("bp_credits", cr(), DEPTH - 1);
      tick();
    end
    io.rd_req_rdy = 1'b1;
    wait_idle("bp_done");
    chk("bp_credits_end", cr(), 0);
    pop_n(4);

    // simultaneous launch and pop at one credit
    for (int i = 0; i < 5; i++)
      push(i == 4 ? 2'b01 : 2'b11,
           64'h6000 + 64'(i) * 64'h40);
    send_cmd(64'h6000, 4, 32'h40, 2'b01);
    repeat (6) tick();
    chk("sim_starved_vld", io.rd_req_vld, 0);
    chk("sim_starved_busy", busy, 1);
    chk("sim_credits0", cr(), 0);
    pop = 1'b1;
    tick();
    chk("sim_credits1", cr(), 1);
    tick();
    pop = 1'b0;
    chk("sim_launch_pop", cr(), 1);
    chk("sim_last_vld", io.rd_req_vld, 1);
    tick();
    chk("sim_idle", busy, 0);
    chk("sim_err_clear", cdt_err, 0);
    pop_n(3);
    chk("sim_full", cr(), DEPTH);
    chk("sat_err_before", cdt_err, 0);
    pop_n(1);
    chk("sat_err", cdt_err, 1);
    chk("sat_credits", cr(), DEPTH);

    // address wrap
    push(2'b11, 64'hFFFF_FFFF_FFFF_FFC0);
    push(2'b11, 64'h0);
    send_cmd(64'hFFFF_FFFF_FFFF_FFC0, 1, 32'h40, 2'b00);
    wait_idle("wrap_done");
    chk("wrap_credits", cr(), DEPTH - 2);
    chk("err_sticky", cdt_err, 1);
    pop_n(2);
    chk("wrap_credits_ret", cr(), DEPTH);

    // reset mid-burst
    for (int i = 0; i < 4; i++)
      push(2'b11, 64'h5000 + 64'(i) * 64'h40);
    send_cmd(64'h5000, 3, 32'h40, 2'b00);
    tick();
    tick();
    chk("mid_vld", io.rd_req_vld, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mrst_cmd_rdy", io.cmd_rdy, 1);
    chk("mrst_vld", io.rd_req_vld, 0);
    chk("mrst_pd", io.rd_req_pd, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", cdt_err, 0);
    chk("mrst_credits", cr(), DEPTH);
    tick();
    rst = 1'b0;
    tick();

    // operation resumes after reset
    push(2'b11, 64'h7000);
    send_cmd(64'h7000, 0, 32'h0, 2'b11);
    wait_idle("post_rst_done");
    chk("post_rst_credits", cr(), DEPTH - 1);
    tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
